// File: rtl/hash_cmp_pkg.sv
// Shared constants and FSM encoding for the hash/target comparator.
package hash_cmp_pkg;

  localparam int unsigned DEF_WIDTH   = 256;
  localparam int unsigned DEF_CHUNK   = 64;
  localparam int unsigned DEF_NONCE_W = 32;
  localparam int unsigned DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    EMIT = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned 3-way compare of one CHUNK-wide slice.
module chunk_cmp #(
  parameter int unsigned CHUNK = 64
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             gt
);

  // Slice ordering; equality is implied when neither flag is set.
  always_comb begin
    lt = (a < b);
    gt = (a > b);
  end

endmodule

// File: rtl/hash_target_cmp.sv
// Hash vs. difficulty-target comparator, one CHUNK slice per cycle, MSB first.
// Hit when hash <= target; hits are held on out_* until consumed.
// Optional macro HASH_CMP_BEST_EN adds best_* outputs tracking the minimum
// hash seen over all decisions since reset/clear.
module hash_target_cmp
  import hash_cmp_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned CHUNK   = DEF_CHUNK,
  parameter int unsigned NONCE_W = DEF_NONCE_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   hash_in,
  input  logic [NONCE_W-1:0] nonce_in,
  input  logic [WIDTH-1:0]   target,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_hash,
  output logic [NONCE_W-1:0] out_nonce,
  output logic               done,
`ifdef HASH_CMP_BEST_EN
  output logic               best_valid,
  output logic [WIDTH-1:0]   best_hash,
  output logic [NONCE_W-1:0] best_nonce,
`endif
  output logic [CNT_W-1:0]   hit_count
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NCHUNK - 1);

  cmp_state_e         state, state_nx;
  logic [WIDTH-1:0]   hash_q, target_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [IDX_W-1:0]   idx;
  logic [CHUNK-1:0]   hash_sl, target_sl;
  logic               sl_lt, sl_gt;
  logic               decide, hit;
  logic               accept;

  assign accept    = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_hash  = out_valid ? hash_q : '0;
  assign out_nonce = out_valid ? nonce_q : '0;
  assign done      = decide;

  // Select the slice under comparison from the latched operands.
  always_comb begin
    hash_sl   = '0;
    target_sl = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx == IDX_W'(i)) begin
        hash_sl   = hash_q[i*CHUNK +: CHUNK];
        target_sl = target_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a  (hash_sl),
    .b  (target_sl),
    .lt (sl_lt),
    .gt (sl_gt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and decision: first unequal slice decides; all-equal is a hit.
  always_comb begin
    state_nx = state;
    decide   = 1'b0;
    hit      = 1'b0;
    case (state)
      IDLE: if (in_valid) state_nx = CMP;
      CMP: begin
        if (sl_lt || (!sl_gt && idx == '0)) begin
          decide   = 1'b1;
          hit      = 1'b1;
          state_nx = EMIT;
        end else if (sl_gt) begin
          decide   = 1'b1;
          state_nx = IDLE;
        end
      end
      EMIT: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture on accept and MSB-first slice index walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_q   <= '0;
      target_q <= '0;
      nonce_q  <= '0;
      idx      <= '0;
    end else if (accept) begin
      hash_q   <= hash_in;
      target_q <= target;
      nonce_q  <= nonce_in;
      idx      <= IDX_MSB;
    end else if (state == CMP && !decide) begin
      idx <= idx - IDX_W'(1);
    end
  end

  // Saturating hit counter; clear overrides a same-cycle hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        hit_count <= '0;
    else if (clear)                    hit_count <= '0;
    else if (hit && hit_count != '1)   hit_count <= hit_count + CNT_W'(1);
  end

`ifdef HASH_CMP_BEST_EN
  // Minimum hash over all decisions; strictly lower replaces, ties keep older.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_valid <= 1'b0;
      best_hash  <= '0;
      best_nonce <= '0;
    end else if (clear) begin
      best_valid <= 1'b0;
      best_hash  <= '0;
      best_nonce <= '0;
    end else if (decide && (!best_valid || hash_q < best_hash)) begin
      best_valid <= 1'b1;
      best_hash  <= hash_q;
      best_nonce <= nonce_q;
    end
  end
`endif

endmodule

// File: tb/tb_hash_target_cmp.sv
// Scoreboard bench for hash_target_cmp: driver pushes expected decisions,
// a negedge monitor pops and compares them against DUT outputs.
module tb_hash_target_cmp;

  localparam int unsigned W  = 256;
  localparam int unsigned C  = 64;
  localparam int unsigned N  = W / C;
  localparam int unsigned NW = 32;
  localparam int unsigned CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  hash_in = '0;
  logic [NW-1:0] nonce_in = '0;
  logic [W-1:0]  target = '0;
  logic          clear = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_hash;
  logic [NW-1:0] out_nonce;
  logic          done;
  logic [CW-1:0] hit_count;
`ifdef HASH_CMP_BEST_EN
  logic          best_valid;
  logic [W-1:0]  best_hash;
  logic [NW-1:0] best_nonce;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hash_target_cmp #(
    .WIDTH   (W),
    .CHUNK   (C),
    .NONCE_W (NW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hash_in   (hash_in),
    .nonce_in  (nonce_in),
    .target    (target),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hash  (out_hash),
    .out_nonce (out_nonce),
    .done      (done),
`ifdef HASH_CMP_BEST_EN
    .best_valid(best_valid),
    .best_hash (best_hash),
    .best_nonce(best_nonce),
`endif
    .hit_count (hit_count)
  );

  typedef struct {
    logic [W-1:0]  h;
    logic [NW-1:0] n;
    bit            hit;
    int unsigned   lat;
  } exp_t;

  typedef struct {
    logic [W-1:0]  h;
    logic [NW-1:0] n;
  } out_t;

  exp_t exp_q[$];
  out_t out_q[$];
  bit   hold_ready = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Reference: hit iff hash <= target; decision latency is set by the
  // position of the most significant differing bit.
  function automatic void ref_model(input logic [W-1:0] h, input logic [W-1:0] t,
                                    output bit hit, output int unsigned lat);
    logic [W-1:0] d;
    hit = (h <= t);
    d   = h ^ t;
    lat = N;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) begin
        lat = N - (i / C);
        break;
      end
    end
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Consumer back-pressure.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard.
  bit            busy = 1'b0;
  int unsigned   cyc = 0;
  bit            chk_next = 1'b0;
  bit            exp_next_hit = 1'b0;
  int            m_cnt = 0;
  bit            prev_hold = 1'b0;
  logic [W-1:0]  prev_h;
  logic [NW-1:0] prev_n;
  bit            m_bv = 1'b0;
  logic [W-1:0]  m_bh = '0;
  logic [NW-1:0] m_bn = '0;

  initial forever begin
    bit            dec_seen;
    bit            dec_hit;
    logic [W-1:0]  dec_h;
    logic [NW-1:0] dec_n;
    exp_t          e;
    out_t          o;
    @(negedge clk);
    dec_seen = 1'b0;
    dec_hit  = 1'b0;
    dec_h    = '0;
    dec_n    = '0;
    if (!rst_n) begin
      exp_q.delete();
      out_q.delete();
      busy = 1'b0; chk_next = 1'b0; prev_hold = 1'b0; m_cnt = 0;
      m_bv = 1'b0; m_bh = '0; m_bn = '0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_hit_count", hit_count, 0);
    end else begin
      chk("hit_count", hit_count, m_cnt);
`ifdef HASH_CMP_BEST_EN
      chk("best_valid", best_valid, m_bv);
      chk("best_hash", best_hash, m_bh);
      chk("best_nonce", best_nonce, m_bn);
`endif
      if (!out_valid) chk("out_zero_when_invalid", (|out_hash) | (|out_nonce), 0);
      if (chk_next) begin
        chk("out_valid_after_decision", out_valid, exp_next_hit);
        chk_next = 1'b0;
      end
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_hash", out_hash, prev_h);
        chk("hold_nonce", out_nonce, prev_n);
      end
      if (out_valid) chk("in_ready_in_emit", in_ready, 0);
      if (busy) begin
        cyc++;
        chk("in_ready_in_cmp", in_ready, 0);
        if (done) begin
          busy = 1'b0;
          if (exp_q.size() == 0) fail("scoreboard_empty_on_done");
          else begin
            e = exp_q.pop_front();
            chk("decision_latency", cyc, e.lat);
            chk_next     = 1'b1;
            exp_next_hit = e.hit;
            dec_seen     = 1'b1;
            dec_hit      = e.hit;
            dec_h        = e.h;
            dec_n        = e.n;
            if (e.hit) begin
              o.h = e.h;
              o.n = e.n;
              out_q.push_back(o);
            end
          end
        end else if (cyc > N) begin
          busy = 1'b0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          fail("decision_timeout");
        end
      end else if (done) begin
        fail("done_without_compare");
      end
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) fail("unexpected_out_valid");
        else begin
          o = out_q.pop_front();
          chk("out_hash", out_hash, o.h);
          chk("out_nonce", out_nonce, o.n);
        end
      end
      if (in_valid && in_ready) begin
        busy = 1'b1;
        cyc  = 0;
      end
      if (clear) m_cnt = 0;
      else if (dec_seen && dec_hit) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (clear) begin
        m_bv = 1'b0; m_bh = '0; m_bn = '0;
      end else if (dec_seen && (!m_bv || dec_h < m_bh)) begin
        m_bv = 1'b1; m_bh = dec_h; m_bn = dec_n;
      end
      prev_hold = out_valid && !out_ready;
      prev_h    = out_hash;
      prev_n    = out_nonce;
    end
  end

  // Offer one candidate; returns at posedge+1 of the accept edge (or of the
  // clear pulse that follows it when clr is set).
  task automatic send(input logic [W-1:0] h, input logic [W-1:0] t,
                      input logic [NW-1:0] n, input bit clr);
    bit          acc;
    int unsigned guard;
    exp_t        e;
    ref_model(h, t, e.hit, e.lat);
    e.h = h;
    e.n = n;
    in_valid = 1'b1; hash_in = h; target = t; nonce_in = n;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    hash_in  = rnd_w();
    target   = rnd_w();
    nonce_in = $urandom;
    if (!acc) begin
      fail("accept_timeout");
      return;
    end
    exp_q.push_back(e);
    if (clr) begin
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int unsigned guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(in_ready && !out_valid && exp_q.size() == 0) && guard < 300);
    if (guard >= 300) fail("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0]  h, t;
    logic [NW-1:0] n;
    int unsigned   k;

    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_hash", out_hash, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Smallest hash under a small target: full-width walk, hit.
    send(256'h1, 256'hFF, 32'h11, 1'b0);
    wait_idle();
    chk("small_hit_count", hit_count, 1);

    // MSB slice decides a miss immediately.
    send({64'hFFFF_FFFF_FFFF_FFFF, 192'h0},
         {64'h0000_FFFF_FFFF_FFFF, {192{1'b1}}}, 32'h22, 1'b0);
    wait_idle();
    chk("miss_hit_count", hit_count, 1);

    // Equal operands: hit after all slices, held under back-pressure.
    h = rnd_w();
    hold_ready = 1'b1;
    send(h, h, 32'h33, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 20);
    if (!out_valid) fail("equal_hit_no_out_valid");
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_hash", out_hash, h);
      chk("stall_out_nonce", out_nonce, 32'h33);
    end
    @(posedge clk); #1;
    hold_ready = 1'b0;
    wait_idle();
    chk("equal_hit_count", hit_count, 2);

    // Three more hits: counter saturates.
    for (int i = 0; i < 3; i++) begin
      h = rnd_w(); t = h;
      h[W-1 -: 64] = 64'h1;
      t[W-1 -: 64] = 64'h2;
      send(h, t, NW'(40 + i), 1'b0);
      wait_idle();
    end
    chk("saturated_hit_count", hit_count, CNT_MAX);

    // Clear in the same cycle as a hit decision.
    h = rnd_w(); t = h;
    h[W-1 -: 64] = 64'h5;
    t[W-1 -: 64] = 64'h9;
    send(h, t, 32'h50, 1'b1);
    wait_idle();
    chk("clear_wins_hit_count", hit_count, 0);

    // Reset during the second slice of a compare.
    h = rnd_w();
    send(h, h, 32'h60, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_out_valid", out_valid, 0);
    chk("post_reset_hit_count", hit_count, 0);
    repeat (4) @(negedge clk);
    chk("post_reset_done", done, 0);
    @(posedge clk); #1;

    // Minimum tracking with a tie.
    send(256'h50, {W{1'b1}}, 32'd1, 1'b0);
    send(256'h30, {W{1'b1}}, 32'd2, 1'b0);
    send(256'h30, {W{1'b1}}, 32'd3, 1'b0);
    send(256'h40, {W{1'b1}}, 32'd4, 1'b0);
    wait_idle();
`ifdef HASH_CMP_BEST_EN
    chk("best_min_hash", best_hash, 256'h30);
    chk("best_min_nonce", best_nonce, 32'd2);
`endif

    // Random traffic with varied deciding slice.
    for (int i = 0; i < 60; i++) begin
      h = rnd_w();
      t = h;
      k = $urandom_range(0, N);
      for (int unsigned s = 0; s < N; s++) begin
        if (s <= k && k < N) t[s*C +: C] = {$urandom, $urandom};
      end
      n = $urandom;
      send(h, t, n, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 9) == 0) begin
        wait_idle();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
      end
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hash_target_cmp.md
HASH_TARGET_CMP -- requirements
Module: hash_target_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 256, hash/target width in bits.
REQ-002 SHALL have parameter CHUNK, default 64, bits compared per cycle; WIDTH multiple of CHUNK.
REQ-003 SHALL have parameter NONCE_W, default 32, nonce tag width.
REQ-004 SHALL have parameter CNT_W, default 16, hit counter width.
REQ-005 SHALL have ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  candidate present
- in_ready  out  1  block can accept a candidate
- hash_in  in  WIDTH  candidate hash
- nonce_in  in  NONCE_W  nonce that produced the hash
- target  in  WIDTH  difficulty target, sampled on accept
- clear  in  1  synchronous clear of hit_count and best registers
- out_valid  out  1  hit result available
- out_ready  in  1  consumer accepts hit
- out_hash  out  WIDTH  winning hash
- out_nonce  out  NONCE_W  winning nonce
- done  out  1  one-cycle pulse per completed compare, hit or miss
- hit_count  out  CNT_W  saturating count of hits

Function
REQ-006 SHALL implement FSM states IDLE, CMP, EMIT.
REQ-007 SHALL drive in_ready=1 only in IDLE.
REQ-008 SHALL, on in_valid&&in_ready, latch hash_in, nonce_in and target, go to CMP with chunk index at MSB chunk.
REQ-009 SHALL, in CMP, compare one CHUNK slice per cycle, MSB slice first, unsigned.
REQ-010 SHALL declare hit on first slice with hash<target, miss on first slice with hash>target, continue on equality.
REQ-011 SHALL declare hit when all slices equal (hit condition is hash<=target).
REQ-012 SHALL go to EMIT on hit, IDLE on miss; latency accept-to-decision 1..WIDTH/CHUNK cycles.
REQ-013 SHALL pulse done for one cycle in the decision cycle.
REQ-014 SHALL, in EMIT, hold out_valid=1 with stable out_hash/out_nonce until out_ready, then go IDLE.
REQ-015 SHALL drive out_hash/out_nonce to zero whenever out_valid=0.
REQ-016 SHALL increment hit_count on each hit decision, saturating at all-ones.
REQ-017 SHALL give clear priority over a same-cycle increment (result 0).
REQ-018 SHALL ignore target/hash_in changes after accept.
REQ-019 SHALL not be affected by clear in FSM state or pending output.

Reset
REQ-020 SHALL, on rst_n low, asynchronously enter IDLE and zero all registers; outputs in_ready=1 after release, all others 0.
REQ-021 SHALL abort any in-flight compare or pending EMIT on reset without emitting.

Configuration
REQ-022 SHALL honour macro HASH_CMP_BEST_EN: when defined, add outputs best_valid(1), best_hash(WIDTH), best_nonce(NONCE_W) tracking the minimum hash over all decisions (hit or miss) since reset/clear; strictly-lower replaces, ties keep older.
REQ-023 SHALL, without HASH_CMP_BEST_EN, omit those ports and registers entirely.
REQ-024 SHALL zero best_* on reset and clear; clear wins over same-cycle update.

Structure
REQ-025 SHALL place default parameter constants and the FSM state encoding in shared package hash_cmp_pkg.
REQ-026 SHALL use one sub-module chunk_cmp: combinational CHUNK-wide 3-way compare (lt, gt).

Verification
REQ-027 SHALL cover: hash=0x00..01, target=0x00..FF (WIDTH=256) -> hit after 4 slices, out_valid, hit_count=1.
REQ-028 SHALL cover: hash MSB slice 0xFFFF.., target MSB 0x0000FFFF.. -> miss after 1 cycle, done pulse, no out_valid.
REQ-029 SHALL cover: hash==target -> hit after WIDTH/CHUNK cycles; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0.
REQ-030 SHALL cover: CNT_W=2, 5 hits -> hit_count saturates at 3; clear with a hit same cycle -> 0.
REQ-031 SHALL cover: rst_n low during CMP slice 2 -> IDLE, no done, no out_valid, in_ready=1 after release.
REQ-032 SHALL cover (HASH_CMP_BEST_EN): hashes 0x50,0x30,0x30,0x40 nonces 1..4 -> best_hash=0x30, best_nonce=2.
